// File: rtl/ro_event_capture_if.sv
// ro_event_capture_if: event-stream handshake between the capture block and
// its consumer.
//   ev_data  : event word {ts, ch}, driven by the producer
//   ev_valid : producer has an event at the head of its queue
//   ev_ready : consumer accepts ev_data when ev_valid & ev_ready
// Modports: master = producer (capture block), slave = consumer (host side).
interface ro_event_capture_if #(
    parameter int W = 20
);
    logic [W-1:0] ev_data;
    logic         ev_valid;
    logic         ev_ready;

    modport master (output ev_data, output ev_valid, input  ev_ready);
    modport slave  (input  ev_data, input  ev_valid, output ev_ready);
endinterface

// File: rtl/ro_event_capture.sv
// ro_event_capture: follows the readout array's gray clock, decodes which
// channel owns each count slot, samples the shared out_mux line for that slot
// and queues every spike as a timestamped event word {ts, ch}.
// Ports:
//   clk, reset : master clock, synchronous active-high reset
//   en         : capture enable (gray tracking continues while low)
//   gray       : gray count from the array's counter
//   out_mux    : shared serial readout line
//   ev         : event stream (master modport: ev_data/ev_valid out, ev_ready in)
//   overflow   : sticky, an event was dropped on a full queue
//   drop_cnt   : saturating count of dropped events
//   gray_err   : sticky, gray input changed in more than one bit
module ro_event_capture #(
    parameter int NCH        = 8,
    parameter int GW         = 17,
    parameter int CHW        = 3,
    parameter int SAMPLE_DLY = 1,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [GW-1:0]            gray,
    input  logic                     out_mux,
    ro_event_capture_if.master       ev,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic                     gray_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = GW + CHW;
    localparam logic [GW-1:0] GONE = 1;
    localparam logic [AW:0]   PONE = 1;

    // ---------------- gray tracking and slot decode ----------------
    logic [GW-1:0]  gray_q;
    logic           primed_q;
    logic [GW-1:0]  diff;
    logic           onehot, multi;
    logic           slot_valid_d;
    logic [CHW-1:0] slot_ch_d;
    logic [GW-1:0]  slot_ts_d;

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int unsigned i = 1; i < GW; i++)
            b[GW-1-i] = b[GW-i] ^ g[GW-1-i];
        return b;
    endfunction

    always_comb begin
        diff         = gray ^ gray_q;
        onehot       = (diff != '0) && ((diff & (diff - GONE)) == '0);
        multi        = (diff != '0) && !onehot;
        // single change in a bit >= NCH is an idle slot
        slot_valid_d = primed_q && en && onehot && (diff[NCH-1:0] != '0);
        slot_ch_d    = '0;
        for (int unsigned i = 0; i < NCH; i++)
            if (diff[i]) slot_ch_d = CHW'(i);
        slot_ts_d    = gray2bin(gray);
    end

    always_ff @(posedge clk) begin
        gray_q <= gray;
        if (reset) primed_q <= 1'b0;
        else       primed_q <= 1'b1;
    end

    // ---------------- sample alignment pipe ----------------
    logic           smp_valid;
    logic [CHW-1:0] smp_ch;
    logic [GW-1:0]  smp_ts;

    generate
        if (SAMPLE_DLY == 0) begin : g_nodly
            assign smp_valid = slot_valid_d;
            assign smp_ch    = slot_ch_d;
            assign smp_ts    = slot_ts_d;
        end else begin : g_dly
            logic           pv_q  [SAMPLE_DLY];
            logic [CHW-1:0] pch_q [SAMPLE_DLY];
            logic [GW-1:0]  pts_q [SAMPLE_DLY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned i = 0; i < SAMPLE_DLY; i++) begin
                        pv_q[i]  <= 1'b0;
                        pch_q[i] <= '0;
                        pts_q[i] <= '0;
                    end
                end else begin
                    pv_q[0]  <= slot_valid_d;
                    pch_q[0] <= slot_ch_d;
                    pts_q[0] <= slot_ts_d;
                    for (int unsigned i = 1; i < SAMPLE_DLY; i++) begin
                        pv_q[i]  <= pv_q[i-1];
                        pch_q[i] <= pch_q[i-1];
                        pts_q[i] <= pts_q[i-1];
                    end
                end
            end

            assign smp_valid = pv_q[SAMPLE_DLY-1];
            assign smp_ch    = pch_q[SAMPLE_DLY-1];
            assign smp_ts    = pts_q[SAMPLE_DLY-1];
        end
    endgenerate

    // ---------------- event FIFO ----------------
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic [AW:0]   count;
    logic [EW-1:0] head_q;
    logic [EW-1:0] push_data;
    logic [AW-1:0] rnext_idx;
    logic          empty, full, push, pop, push_ok, drop;
    logic          overflow_q, gray_err_q;
    logic [7:0]    drop_cnt_q;

    always_comb begin
        empty     = (wptr_q == rptr_q);
        full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        count     = wptr_q - rptr_q;
        push_data = {smp_ts, smp_ch};
        push      = smp_valid && out_mux;
        pop       = !empty && ev.ev_ready;
        push_ok   = push && (!full || pop);
        drop      = push && full && !pop;
        rnext_idx = rptr_q[AW-1:0] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            gray_err_q <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PONE;
            if (pop)     rptr_q <= rptr_q + PONE;
            // head register: new push becomes head when the queue is (or is
            // about to become) empty; otherwise a pop preloads the next entry
            if (push_ok && (empty || (pop && count == PONE)))
                head_q <= push_data;
            else if (pop && count > PONE)
                head_q <= mem_q[rnext_idx];
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            if (primed_q && en && multi) gray_err_q <= 1'b1;
        end
    end

    assign ev.ev_data  = head_q;
    assign ev.ev_valid = !empty;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;
    assign gray_err    = gray_err_q;
endmodule
